// File: rtl/axi_rchan_buffer.sv
// axi_rchan_buffer: FWFT buffer for AXI4 R-channel beats with burst, error and length tracking
module axi_rchan_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int MAX_LEN = 16
) (
  input  logic aclk,
  input  logic areset,
  input  logic s_rvalid,
  output logic s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0] s_rresp,
  input  logic s_rlast,
  output logic m_tvalid,
  input  logic m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic m_tlast,
  output logic m_terr,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0] burst_count,
  output logic err_sticky,
  output logic len_err,
  input  logic clear_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_W+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] beat_idx;
  logic push, pop, at_max, last_tag, err_tag;
  assign s_rready = level != LW'(DEPTH);
  assign m_tvalid = level != '0;
  assign push = s_rvalid && s_rready;
  assign pop = m_tvalid && m_tready;
  assign at_max = beat_idx == 8'(MAX_LEN - 1);
  assign last_tag = s_rlast || at_max;
  // SLVERR/DECERR only; EXOKAY is a successful response
  assign err_tag = s_rresp == 2'd2 || s_rresp == 2'd3;
  assign {m_tdata, m_tlast, m_terr} = mem[rd_ptr];
  always_ff @(posedge aclk)
    if (push) mem[wr_ptr] <= {s_rdata, last_tag, err_tag};
  always_ff @(posedge aclk)
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      beat_idx <= '0;
      burst_count <= '0;
      err_sticky <= 1'b0;
      len_err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + LW'(push) - LW'(pop);
      beat_idx <= push ? (last_tag ? 8'd0 : beat_idx + 8'd1) : beat_idx;
      burst_count <= burst_count + 16'(push && last_tag);
      err_sticky <= (push && err_tag) || (err_sticky && !clear_err);
      len_err <= (push && at_max && !s_rlast) || (len_err && !clear_err);
    end
endmodule

// File: tb/tb_axi_rchan_buffer.sv
// tb_axi_rchan_buffer: randomized and directed checks against a queue-based reference model
module tb_axi_rchan_buffer;
  localparam int DEPTH = 8;
  localparam int MAX_LEN = 16;
  logic aclk = 1'b0, areset = 1'b0;
  logic s_rvalid = 1'b0, s_rready, s_rlast = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [1:0] s_rresp = '0;
  logic m_tvalid, m_tready = 1'b0, m_tlast, m_terr;
  logic [31:0] m_tdata;
  logic [3:0] level;
  logic [15:0] burst_count;
  logic err_sticky, len_err, clear_err = 1'b0;
  typedef struct {logic [31:0] d; logic l; logic e;} beat_t;
  beat_t exp_q[$];
  int m_beats;
  logic [15:0] m_bursts;
  logic m_err, m_len;
  int n_cmp = 0, n_bad = 0;

  axi_rchan_buffer #(.DATA_W(32), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .aclk(aclk), .areset(areset),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_terr(m_terr),
    .level(level), .burst_count(burst_count), .err_sticky(err_sticky), .len_err(len_err),
    .clear_err(clear_err)
  );

  always #5 aclk = ~aclk;

  function automatic logic [23:0] dut_st();
    return {m_tvalid, s_rready, level, burst_count, err_sticky, len_err};
  endfunction

  function automatic logic [23:0] exp_st();
    return {exp_q.size() != 0, exp_q.size() < DEPTH, 4'(exp_q.size()), m_bursts, m_err, m_len};
  endfunction

  function automatic logic [33:0] exp_head();
    return {exp_q[0].d, exp_q[0].l, exp_q[0].e};
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    s_rvalid = 1'b0;
    m_tready = 1'b0;
    clear_err = 1'b0;
    @(posedge aclk);
    exp_q.delete();
    m_beats = 0;
    m_bursts = '0;
    m_err = 1'b0;
    m_len = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
  endtask

  // drives one cycle from a negedge and advances the model by the spec's handshake rules
  task automatic tick(input logic v, input logic [31:0] d, input logic [1:0] r, input logic l,
                      input logic rdy, input logic clr, output logic pushed);
    logic push, pop, lt;
    s_rvalid = v; s_rdata = d; s_rresp = r; s_rlast = l; m_tready = rdy; clear_err = clr;
    push = v && exp_q.size() < DEPTH;
    pop = rdy && exp_q.size() != 0;
    @(posedge aclk);
    if (pop) void'(exp_q.pop_front());
    if (clr) begin m_err = 1'b0; m_len = 1'b0; end
    if (push) begin
      lt = l || (m_beats + 1 == MAX_LEN);
      if (!l && m_beats + 1 == MAX_LEN) m_len = 1'b1;
      if (r >= 2'd2) m_err = 1'b1;
      exp_q.push_back('{d, lt, r >= 2'd2});
      if (lt) begin m_beats = 0; m_bursts++; end else m_beats++;
    end
    pushed = push;
    @(negedge aclk);
    s_rvalid = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_st() !== {1'b0, 1'b1, 4'd0, 16'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL reset: got %h want %h", dut_st(), {1'b0, 1'b1, 4'd0, 16'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_basic();
    int i = 0;
    logic p;
    do_reset();
    for (int c = 0; c < 30 && (i < 4 || exp_q.size() != 0); c++) begin
      n_cmp++;
      if (dut_st() !== exp_st()) begin n_bad++; $display("FAIL basic status c=%0d: got %h want %h", c, dut_st(), exp_st()); end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if ({m_tdata, m_tlast, m_terr} !== exp_head()) begin n_bad++; $display("FAIL basic head c=%0d: got %h want %h", c, {m_tdata, m_tlast, m_terr}, exp_head()); end
      end
      tick(i < 4, 32'hdeadbeef + i, 2'd0, i == 3, 1'b1, 1'b0, p);
      if (p) i++;
    end
    n_cmp++;
    if (i != 4 || exp_q.size() != 0 || burst_count !== 16'd1 || level !== 4'd0) begin
      n_bad++; $display("FAIL basic done: sent %0d left %0d bursts %0d level %0d, want 4 0 1 0", i, exp_q.size(), burst_count, level);
    end
  endtask

  task automatic test_backpressure();
    int i = 0;
    logic p;
    for (int c = 0; c < 60 && (i < 10 || exp_q.size() != 0); c++) begin
      n_cmp++;
      if (dut_st() !== exp_st()) begin n_bad++; $display("FAIL bp status c=%0d: got %h want %h", c, dut_st(), exp_st()); end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if ({m_tdata, m_tlast, m_terr} !== exp_head()) begin n_bad++; $display("FAIL bp head c=%0d: got %h want %h", c, {m_tdata, m_tlast, m_terr}, exp_head()); end
      end
      if (c == 14) begin
        n_cmp++;
        if (s_rready !== 1'b0 || level !== 4'd8) begin n_bad++; $display("FAIL bp full: rready %b level %0d, want 0 8", s_rready, level); end
      end
      tick(i < 10, 32'hb000 + i, 2'd0, i == 9, c >= 15, 1'b0, p);
      if (p) i++;
    end
    n_cmp++;
    if (i != 10 || exp_q.size() != 0) begin n_bad++; $display("FAIL bp done: sent %0d/10 left %0d", i, exp_q.size()); end
  endtask

  task automatic test_wrap();
    int i = 0;
    logic p;
    for (int c = 0; c < 100 && (i < 20 || exp_q.size() != 0); c++) begin
      n_cmp++;
      if (dut_st() !== exp_st()) begin n_bad++; $display("FAIL wrap status c=%0d: got %h want %h", c, dut_st(), exp_st()); end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if ({m_tdata, m_tlast, m_terr} !== exp_head()) begin n_bad++; $display("FAIL wrap head c=%0d: got %h want %h", c, {m_tdata, m_tlast, m_terr}, exp_head()); end
      end
      tick(i < 20, 32'hc000 + i, 2'd0, i % 5 == 4, c >= 8 && (c % 2 == 0), 1'b0, p);
      if (p) i++;
    end
    n_cmp++;
    if (i != 20 || exp_q.size() != 0) begin n_bad++; $display("FAIL wrap done: sent %0d/20 left %0d", i, exp_q.size()); end
  endtask

  task automatic test_error();
    int i = 0;
    logic p;
    logic [1:0] rs [4];
    rs = '{2'd0, 2'd2, 2'd1, 2'd0};
    do_reset();
    for (int c = 0; c < 30 && (i < 4 || exp_q.size() != 0); c++) begin
      n_cmp++;
      if (dut_st() !== exp_st()) begin n_bad++; $display("FAIL err status c=%0d: got %h want %h", c, dut_st(), exp_st()); end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if ({m_tdata, m_tlast, m_terr} !== exp_head()) begin n_bad++; $display("FAIL err head c=%0d: got %h want %h", c, {m_tdata, m_tlast, m_terr}, exp_head()); end
      end
      tick(i < 4, 32'he000 + i, rs[i % 4], i == 3, 1'b1, 1'b0, p);
      if (p) i++;
    end
    repeat (3) tick(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0, p);
    n_cmp++;
    if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL err held: got %b want 1", err_sticky); end
    tick(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b1, p);
    n_cmp++;
    if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL err clear: got %b want 0", err_sticky); end
    tick(1'b1, 32'h5a5a5a5a, 2'd3, 1'b1, 1'b0, 1'b1, p);
    n_cmp++;
    if (err_sticky !== 1'b1 || m_terr !== 1'b1) begin n_bad++; $display("FAIL err set+clear: sticky %b terr %b want 1 1", err_sticky, m_terr); end
    tick(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0, p);
    n_cmp++;
    if (dut_st() !== exp_st()) begin n_bad++; $display("FAIL err final: got %h want %h", dut_st(), exp_st()); end
  endtask

  task automatic test_len_overrun();
    int i = 0;
    logic p;
    do_reset();
    for (int c = 0; c < 60 && (i < 20 || exp_q.size() != 0); c++) begin
      n_cmp++;
      if (dut_st() !== exp_st()) begin n_bad++; $display("FAIL len status c=%0d: got %h want %h", c, dut_st(), exp_st()); end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if ({m_tdata, m_tlast, m_terr} !== exp_head()) begin n_bad++; $display("FAIL len head c=%0d: got %h want %h", c, {m_tdata, m_tlast, m_terr}, exp_head()); end
      end
      tick(i < 20, 32'h1000 + i, 2'd0, 1'b0, 1'b1, 1'b0, p);
      if (p) i++;
    end
    n_cmp++;
    if (i != 20 || len_err !== 1'b1 || burst_count !== 16'd1) begin
      n_bad++; $display("FAIL len done: sent %0d len_err %b bursts %0d, want 20 1 1", i, len_err, burst_count);
    end
    tick(1'b1, 32'h2000, 2'd0, 1'b1, 1'b1, 1'b1, p);
    n_cmp++;
    if (len_err !== 1'b0 || burst_count !== 16'd2 || m_tlast !== 1'b1) begin
      n_bad++; $display("FAIL len resync: len_err %b bursts %0d tlast %b, want 0 2 1", len_err, burst_count, m_tlast);
    end
    tick(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0, p);
  endtask

  task automatic test_mid_reset();
    int i = 0;
    logic p;
    tick(1'b1, 32'h7000, 2'd0, 1'b0, 1'b0, 1'b0, p);
    tick(1'b1, 32'h7001, 2'd0, 1'b0, 1'b0, 1'b0, p);
    do_reset();
    n_cmp++;
    if (m_tvalid !== 1'b0 || level !== 4'd0 || burst_count !== 16'd0) begin
      n_bad++; $display("FAIL midrst: tvalid %b level %0d bursts %0d, want 0 0 0", m_tvalid, level, burst_count);
    end
    for (int c = 0; c < 30 && (i < 4 || exp_q.size() != 0); c++) begin
      n_cmp++;
      if (dut_st() !== exp_st()) begin n_bad++; $display("FAIL midrst status c=%0d: got %h want %h", c, dut_st(), exp_st()); end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if ({m_tdata, m_tlast, m_terr} !== exp_head()) begin n_bad++; $display("FAIL midrst head c=%0d: got %h want %h", c, {m_tdata, m_tlast, m_terr}, exp_head()); end
      end
      tick(i < 4, 32'h8000 + i, 2'd0, i == 3, 1'b1, 1'b0, p);
      if (p) i++;
    end
    n_cmp++;
    if (i != 4 || exp_q.size() != 0 || burst_count !== 16'd1) begin
      n_bad++; $display("FAIL midrst done: sent %0d left %0d bursts %0d, want 4 0 1", i, exp_q.size(), burst_count);
    end
  endtask

  task automatic test_random();
    logic p;
    for (int c = 0; c < 600; c++) begin
      n_cmp++;
      if (dut_st() !== exp_st()) begin n_bad++; $display("FAIL rand status c=%0d: got %h want %h", c, dut_st(), exp_st()); end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if ({m_tdata, m_tlast, m_terr} !== exp_head()) begin n_bad++; $display("FAIL rand head c=%0d: got %h want %h", c, {m_tdata, m_tlast, m_terr}, exp_head()); end
      end
      if (c < 560)
        tick($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 20) == 0, p);
      else
        tick(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0, p);
    end
    n_cmp++;
    if (exp_q.size() != 0 || m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rand drain: left %0d tvalid %b", exp_q.size(), m_tvalid); end
  endtask

  initial begin
    @(negedge aclk);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_error();
    test_len_overrun();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axi_rchan_buffer.md
Name: axi_rchan_buffer

Overview:
- Downstream stage of the AXI4 master read path. Consumes R-channel beats (rdata/rresp/rlast) under valid/ready and buffers them in a first-word-fall-through FIFO.
- Re-emits them as a ready/valid stream with last and error tags, decoupling master read-data return from the consumer.
- Tracks beat and burst counts, flags error responses, and flags bursts that overrun the expected length.

Parameters:
DATA_W, 32, width of rdata / stream data
DEPTH, 8, FIFO entries; power of 2, >= 2
MAX_LEN, 16, maximum beats per burst before a length error is declared (1..256)

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous reset, active-high
s_rvalid  in  1  R-channel beat valid
s_rready  out  1  R-channel ready
s_rdata  in  DATA_W  read data
s_rresp  in  2  read response (0 OKAY, 1 EXOKAY, 2 SLVERR, 3 DECERR)
s_rlast  in  1  last beat of burst
m_tvalid  out  1  output beat valid
m_tready  in  1  output beat accepted
m_tdata  out  DATA_W  output data
m_tlast  out  1  output last-of-burst
m_terr  out  1  beat carried SLVERR/DECERR
level  out  $clog2(DEPTH)+1  current FIFO occupancy
burst_count  out  16  completed bursts accepted on input, wraps 0xFFFF->0
err_sticky  out  1  any error response seen since reset/clear
len_err  out  1  sticky: burst exceeded MAX_LEN beats without rlast
clear_err  in  1  one-cycle pulse clears err_sticky and len_err

Behaviour:
- Reset (areset=1 at edge): level=0, FIFO empty, rd/wr pointers=0, beat_idx=0, burst_count=0, err_sticky=0, len_err=0. Outputs during/after reset: s_rready=1 (when DEPTH>0 free), m_tvalid=0, m_tdata/m_tlast/m_terr don't-care but driven from entry 0.
- Reset mid-burst: all in-flight entries discarded; beat_idx restarts at 0; no partial output beat survives.
- Push: occurs on edge when s_rvalid && s_rready. s_rready = (level != DEPTH), derived from registered level only. No combinational path from m_tready to s_rready. A full FIFO stalls input even if a pop happens the same cycle.
- Pop: occurs on edge when m_tvalid && m_tready. m_tvalid = (level != 0). m_tdata/m_tlast/m_terr read combinationally from head entry (FWFT).
- Latency: beat pushed at edge N is presented with m_tvalid=1 after edge N (one cycle), provided the FIFO was empty.
- Simultaneous push and pop: level unchanged, both pointers advance. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Stored entry: {data, last_tag, err_tag}.
  - err_tag = s_rresp[1].
  - last_tag = s_rlast OR forced-last (below).
- Beat counter beat_idx (8-bit):
  - Increments on each push.
  - Returns to 0 on a push with last_tag=1.
- Length check: if a push occurs with beat_idx == MAX_LEN-1 and s_rlast=0:
  - len_err <= 1.
  - That entry's last_tag is forced to 1.
  - beat_idx returns to 0 (the stream is resynchronised).
- burst_count increments on every push with last_tag=1, including forced-last.
- err_sticky <= 1 on any push with s_rresp[1]=1.
- clear_err takes priority over set only for set events from earlier cycles. A set and a clear in the same cycle leave the flag = 1.
- EXOKAY (1) is treated as OKAY: m_terr=0.
- Stream holds stable: m_tdata/m_tlast/m_terr are constant while m_tvalid=1 && m_tready=0.

Test Plan:
- Reset release, 4-beat burst:
  - Stimulus: data 0xdeadbeef..0xdeadbef2, rresp=0, rlast on beat 3, m_tready=1.
  - Response: four output beats in order, each one cycle after its push; m_tlast only on 0xdeadbef2; burst_count=1, level back to 0.
- Backpressure:
  - Stimulus: m_tready=0, 10 beats offered continuously.
  - Response: s_rready drops after 8 pushes, level=8. Then raise m_tready: all 10 emerge in order with no loss or duplication. Level never exceeds 8.
- Simultaneous push/pop at level=8 with pointer wrap:
  - Stimulus: 20 beats streamed with m_tready toggling 1/0.
  - Response: data order preserved across pointer wrap; level never exceeds 8.
- Error response:
  - Stimulus: beat 2 of a 4-beat burst has rresp=2, beat 3 has rresp=1.
  - Response: m_terr=1 only on beat 2; err_sticky=1 and held. A clear_err pulse returns it to 0.
- Length overrun (MAX_LEN=16):
  - Stimulus: 20 beats with no rlast.
  - Response: beat 16 carries m_tlast=1, len_err=1, burst_count=1. Beats 17-20 start a new burst.
- Mid-burst reset:
  - Stimulus: areset pulsed after 2 beats of a burst.
  - Response: m_tvalid=0, level=0, burst_count=0 the next cycle. A following 4-beat burst is delivered intact.
